led_pattern_sequencer: RTL and testbench



---
 rtl/led_pattern_sequencer.sv | 137 +++++++++++++
 tb/tb_led_pattern_sequencer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_sequencer.sv
// LED pattern sequencer: prescaled stepping of a pattern register with four
// step modes (rotate right, rotate left, bounce, Johnson fill).
// Ports: clk, rst (async, active-high), enable (run/freeze),
//   cmd_valid/cmd_ready handshake carrying cmd_mode, cmd_period, cmd_seed,
//   pattern (registered LED drive), step_cnt (steps since load, wraps),
//   tick (one-cycle pulse in the first cycle a stepped pattern appears).
module led_pattern_sequencer #(
    parameter int WIDTH  = 32,
    parameter int NCOUNT = 25,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_mode,
    input  logic [NCOUNT-1:0] cmd_period,
    input  logic [WIDTH-1:0]  cmd_seed,
    output logic [WIDTH-1:0]  pattern,
    output logic [CNT_W-1:0]  step_cnt,
    output logic              tick
);

    localparam int BW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] M_ROT_R  = 2'd0;
    localparam logic [1:0] M_ROT_L  = 2'd1;
    localparam logic [1:0] M_BOUNCE = 2'd2;
    localparam logic [1:0] M_FILL   = 2'd3;

    typedef enum logic {RUN, LOAD} state_t;

    state_t state, state_nx;

    logic [1:0]        mode, h_mode;
    logic [NCOUNT-1:0] period, presc, h_period;
    logic [WIDTH-1:0]  h_seed, step_pat;
    logic              dir;  // 0 = left, 1 = right
    logic [BW-1:0]     bcnt;
    logic              accept;
    logic              do_step;
    logic [WIDTH-1:0]  rot_r, rot_l;

    // FSM next-state and handshake
    always_comb begin
        state_nx  = state;
        cmd_ready = 1'b0;
        accept    = 1'b0;
        case (state)
            RUN: begin
                cmd_ready = 1'b1;
                accept    = cmd_valid;
                if (cmd_valid)
                    state_nx = LOAD;
            end
            LOAD: state_nx = RUN;
            default: state_nx = RUN;
        endcase
    end

    // A step needs RUN, enable, an expired prescaler and no accept this edge;
    // an accept coinciding with expiry drops the step.
    assign do_step = (state == RUN) && enable && !accept
                     && (presc == '0);

    assign rot_r = {pattern[0], pattern[WIDTH-1:1]};
    assign rot_l = {pattern[WIDTH-2:0], pattern[WIDTH-1]};

    always_comb begin
        step_pat = rot_r;
        case (mode)
            M_ROT_R:  step_pat = rot_r;
            M_ROT_L:  step_pat = rot_l;
            M_BOUNCE: step_pat = dir ? rot_r : rot_l;
            M_FILL:   step_pat = {~pattern[0], pattern[WIDTH-1:1]};
            default:  step_pat = rot_r;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= RUN;
        else
            state <= state_nx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pattern  <= {{(WIDTH-1){1'b1}}, 1'b0};
            step_cnt <= '0;
            tick     <= 1'b0;
            mode     <= M_ROT_R;
            period   <= '1;
            presc    <= '1;
            dir      <= 1'b0;
            bcnt     <= '0;
            h_mode   <= M_ROT_R;
            h_period <= '0;
            h_seed   <= '0;
        end else begin
            tick <= 1'b0;
            if (state == LOAD) begin
                pattern  <= h_seed;
                mode     <= h_mode;
                period   <= h_period;
                presc    <= h_period;
                step_cnt <= '0;
                dir      <= 1'b0;
                bcnt     <= '0;
            end else if (accept) begin
                h_mode   <= cmd_mode;
                h_period <= cmd_period;
                h_seed   <= cmd_seed;
            end else if (enable) begin
                if (do_step) begin
                    presc    <= period;
                    pattern  <= step_pat;
                    step_cnt <= step_cnt + CNT_W'(1);
                    tick     <= 1'b1;
                    if (mode == M_BOUNCE) begin
                        // WIDTH-1 steps per direction, then turn around
                        if (bcnt == BW'(WIDTH - 2)) begin
                            dir  <= ~dir;
                            bcnt <= '0;
                        end else begin
                            bcnt <= bcnt + BW'(1);
                        end
                    end
                end else begin
                    presc <= presc - NCOUNT'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Testbench for led_pattern_sequencer: directed scenarios per feature.
// Uses an 8-bit prescaler so the power-on step arrives after 256 cycles.
module tb_led_pattern_sequencer;

    localparam int WIDTH  = 32;
    localparam int NCOUNT = 8;
    localparam int CNT_W  = 8;

    logic              clk;
    logic              rst;
    logic              enable;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_mode;
    logic [NCOUNT-1:0] cmd_period;
    logic [WIDTH-1:0]  cmd_seed;
    logic [WIDTH-1:0]  pattern;
    logic [CNT_W-1:0]  step_cnt;
    logic              tick;

    int checks;
    int errors;

    led_pattern_sequencer #(
        .WIDTH (WIDTH),
        .NCOUNT(NCOUNT),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_mode  (cmd_mode),
        .cmd_period(cmd_period),
        .cmd_seed  (cmd_seed),
        .pattern   (pattern),
        .step_cnt  (step_cnt),
        .tick      (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Present a command for one accept edge, then let the LOAD edge pass.
    task automatic send_cmd(input logic [1:0] m, input logic [NCOUNT-1:0] p,
                            input logic [WIDTH-1:0] s);
        cmd_mode   = m;
        cmd_period = p;
        cmd_seed   = s;
        cmd_valid  = 1'b1;
        cyc();
        cmd_valid  = 1'b0;
        cyc();
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if (pattern !== 32'hFFFF_FFFE) begin
            errors++;
            $display("FAIL reset_pattern: got %h want FFFFFFFE", pattern);
        end
        checks++;
        if (step_cnt !== 8'd0 || tick !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ctrl: cnt=%0d tick=%b rdy=%b want 0 0 1",
                     step_cnt, tick, cmd_ready);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_power_on();
        for (int i = 1; i <= 255; i++) begin
            cyc();
            checks++;
            if (pattern !== 32'hFFFF_FFFE || tick !== 1'b0) begin
                errors++;
                $display("FAIL poweron_hold[%0d]: got %h tick=%b want FFFFFFFE 0",
                         i, pattern, tick);
            end
        end
        cyc();
        checks++;
        if (pattern !== 32'h7FFF_FFFF || tick !== 1'b1 || step_cnt !== 8'd1) begin
            errors++;
            $display("FAIL poweron_step: got %h tick=%b cnt=%0d want 7FFFFFFF 1 1",
                     pattern, tick, step_cnt);
        end
    endtask

    task automatic test_rot_r();
        logic [WIDTH-1:0] exp_pat;
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL rotr_ready_pre: got %b want 1", cmd_ready);
        end
        cmd_mode   = 2'd0;
        cmd_period = 8'd3;
        cmd_seed   = 32'hFFFF_FFFE;
        cmd_valid  = 1'b1;
        cyc();
        cmd_valid  = 1'b0;
        checks++;
        if (cmd_ready !== 1'b0 || pattern !== 32'h7FFF_FFFF) begin
            errors++;
            $display("FAIL rotr_accept: rdy=%b pat=%h want 0 7FFFFFFF",
                     cmd_ready, pattern);
        end
        cyc();
        checks++;
        if (cmd_ready !== 1'b1 || pattern !== 32'hFFFF_FFFE
            || step_cnt !== 8'd0 || tick !== 1'b0) begin
            errors++;
            $display("FAIL rotr_load: rdy=%b pat=%h cnt=%0d tick=%b",
                     cmd_ready, pattern, step_cnt, tick);
        end
        for (int i = 1; i <= 8; i++) begin
            cyc();
            exp_pat = (i < 4) ? 32'hFFFF_FFFE :
                      (i < 8) ? 32'h7FFF_FFFF : 32'hBFFF_FFFF;
            checks++;
            if (pattern !== exp_pat || tick !== (i % 4 == 0)
                || step_cnt !== CNT_W'(i / 4)) begin
                errors++;
                $display("FAIL rotr_step[%0d]: pat=%h tick=%b cnt=%0d want %h",
                         i, pattern, tick, step_cnt, exp_pat);
            end
        end
    endtask

    task automatic test_rot_l_freeze();
        logic [WIDTH-1:0] exp_tab [3];
        exp_tab[0] = 32'hFFFF_FFFD;
        exp_tab[1] = 32'hFFFF_FFFB;
        exp_tab[2] = 32'hFFFF_FFF7;
        send_cmd(2'd1, 8'd0, 32'hFFFF_FFFE);
        for (int i = 0; i < 3; i++) begin
            cyc();
            checks++;
            if (pattern !== exp_tab[i] || tick !== 1'b1) begin
                errors++;
                $display("FAIL rotl_step[%0d]: got %h tick=%b want %h",
                         i, pattern, tick, exp_tab[i]);
            end
        end
        enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            checks++;
            if (pattern !== 32'hFFFF_FFF7 || step_cnt !== 8'd3 || tick !== 1'b0) begin
                errors++;
                $display("FAIL freeze[%0d]: pat=%h cnt=%0d tick=%b",
                         i, pattern, step_cnt, tick);
            end
        end
        enable = 1'b1;
    endtask

    task automatic test_bounce();
        logic [WIDTH-1:0] exp_pat;
        send_cmd(2'd2, 8'd0, 32'h0000_0001);
        for (int k = 1; k <= 63; k++) begin
            cyc();
            exp_pat = '0;
            if (k == 31) exp_pat = 32'h8000_0000;
            if (k == 32) exp_pat = 32'h4000_0000;
            if (k == 62) exp_pat = 32'h0000_0001;
            if (k == 63) exp_pat = 32'h0000_0002;
            if (exp_pat != '0) begin
                checks++;
                if (pattern !== exp_pat || step_cnt !== CNT_W'(k)) begin
                    errors++;
                    $display("FAIL bounce[%0d]: got %h cnt=%0d want %h",
                             k, pattern, step_cnt, exp_pat);
                end
            end
        end
    endtask

    task automatic test_fill();
        logic [WIDTH-1:0] exp_pat;
        send_cmd(2'd3, 8'd0, 32'h0000_0000);
        for (int k = 1; k <= 256; k++) begin
            cyc();
            exp_pat = 32'h1234_5678;
            if (k == 1)  exp_pat = 32'h8000_0000;
            if (k == 2)  exp_pat = 32'hC000_0000;
            if (k == 32) exp_pat = 32'hFFFF_FFFF;
            if (k == 64) exp_pat = 32'h0000_0000;
            if (exp_pat != 32'h1234_5678) begin
                checks++;
                if (pattern !== exp_pat) begin
                    errors++;
                    $display("FAIL fill[%0d]: got %h want %h", k, pattern, exp_pat);
                end
            end
        end
        checks++;
        if (step_cnt !== 8'd0 || pattern !== 32'h0000_0000) begin
            errors++;
            $display("FAIL fill_wrap: cnt=%0d pat=%h want 0 00000000",
                     step_cnt, pattern);
        end
    endtask

    task automatic test_accept_on_zero();
        cmd_mode   = 2'd0;
        cmd_period = 8'd5;
        cmd_seed   = 32'hA5A5_0F0F;
        cmd_valid  = 1'b1;
        cyc();
        cmd_valid  = 1'b0;
        checks++;
        if (tick !== 1'b0 || pattern !== 32'h0000_0000) begin
            errors++;
            $display("FAIL accz_accept: tick=%b pat=%h want 0 00000000",
                     tick, pattern);
        end
        cyc();
        checks++;
        if (tick !== 1'b0 || pattern !== 32'hA5A5_0F0F || step_cnt !== 8'd0) begin
            errors++;
            $display("FAIL accz_load: tick=%b pat=%h cnt=%0d want 0 A5A50F0F 0",
                     tick, pattern, step_cnt);
        end
    endtask

    task automatic test_reset_in_load();
        cmd_mode   = 2'd1;
        cmd_period = 8'd2;
        cmd_seed   = 32'h1234_5678;
        cmd_valid  = 1'b1;
        cyc();
        cmd_valid  = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if (pattern !== 32'hFFFF_FFFE || cmd_ready !== 1'b1 || step_cnt !== 8'd0) begin
            errors++;
            $display("FAIL rstload: pat=%h rdy=%b cnt=%0d want FFFFFFFE 1 0",
                     pattern, cmd_ready, step_cnt);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            checks++;
            if (pattern !== 32'hFFFF_FFFE || tick !== 1'b0) begin
                errors++;
                $display("FAIL rstload_after[%0d]: pat=%h tick=%b want FFFFFFFE 0",
                         i, pattern, tick);
            end
        end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rst        = 1'b1;
        enable     = 1'b1;
        cmd_valid  = 1'b0;
        cmd_mode   = 2'd0;
        cmd_period = '0;
        cmd_seed   = '0;
        test_reset();
        test_power_on();
        test_rot_r();
        test_rot_l_freeze();
        test_bounce();
        test_fill();
        test_accept_on_zero();
        test_reset_in_load();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
